// File: rtl/choose_scene_pkg.sv
// Shared definitions for the grid selection scene:
// pixel classes, default colours and address width.
package choose_scene_pkg;

    localparam int ADDR_W = 17;

    localparam logic [11:0] DEF_FRAME_COLOR = 12'h000;
    localparam logic [11:0] DEF_BG_COLOR    = 12'hfff;

    typedef enum logic [1:0] {
        CLS_BG    = 2'd0,
        CLS_TILE  = 2'd1,
        CLS_FRAME = 2'd2
    } pix_cls_e;

    // Index width that stays legal for a count of one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grid_cursor.sv
// Cursor position, NAVIGATE/LOCKED selection FSM,
// highlight blink timer and the chosen pulse.
module grid_cursor
    import choose_scene_pkg::*;
#(
    parameter int COLS         = 4,
    parameter int ROWS         = 2,
    parameter int BLINK_FRAMES = 16,
    parameter int CW           = idx_w(COLS),
    parameter int RW           = idx_w(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_confirm,
    input  logic          btn_back,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          locked_o,
    output logic          chosen_o,
    output logic          frame_visible_o
);

    localparam int BW = idx_w(BLINK_FRAMES);

    localparam logic [0:0] NAVIGATE = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          vis_q, vis_d;
    logic          chosen_q, chosen_d;
    logic          moved;

    // Button arbitration (back wins, down loses) and cursor moves.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        chosen_d = 1'b0;
        moved    = 1'b0;
        if (state_q == NAVIGATE) begin
            if (btn_back) begin
                moved = 1'b0;
            end else if (btn_confirm) begin
                state_d  = LOCKED;
                chosen_d = 1'b1;
            end else if (btn_left) begin
                col_d = (col_q == '0) ? COL_MAX
                                      : col_q - CW'(1);
                moved = 1'b1;
            end else if (btn_right) begin
                col_d = (col_q == COL_MAX) ? '0
                                           : col_q + CW'(1);
                moved = 1'b1;
            end else if (btn_up) begin
                row_d = (row_q == '0) ? ROW_MAX
                                      : row_q - RW'(1);
                moved = 1'b1;
            end else if (btn_down) begin
                row_d = (row_q == ROW_MAX) ? '0
                                           : row_q + RW'(1);
                moved = 1'b1;
            end
        end else if (btn_back) begin
            state_d = NAVIGATE;
        end
    end

    // Blink timer: held while locked, restarted by any move.
    always_comb begin
        blink_d = blink_q;
        vis_d   = vis_q;
        if (state_d == LOCKED || moved) begin
            blink_d = '0;
            vis_d   = 1'b1;
        end else if (frame_tick) begin
            if (blink_q == BLK_MAX) begin
                blink_d = '0;
                vis_d   = ~vis_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end
    end

    // Cursor state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NAVIGATE;
            col_q    <= '0;
            row_q    <= '0;
            blink_q  <= '0;
            vis_q    <= 1'b1;
            chosen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            blink_q  <= blink_d;
            vis_q    <= vis_d;
            chosen_q <= chosen_d;
        end
    end

    assign col_o           = col_q;
    assign row_o           = row_q;
    assign locked_o        = (state_q == LOCKED);
    assign chosen_o        = chosen_q;
    assign frame_visible_o = vis_q;

endmodule

// File: rtl/choose_grid_scene.sv
// Selection screen: tile grid from a sprite sheet with a
// blinking frame around the cursor tile.
module choose_grid_scene
    import choose_scene_pkg::*;
#(
    parameter int          COLS         = 4,
    parameter int          ROWS         = 2,
    parameter int          IMG          = 60,
    parameter int          SCALE_SH     = 1,
    parameter int          H0           = 20,
    parameter int          V0           = 80,
    parameter int          H_PITCH      = 160,
    parameter int          V_PITCH      = 160,
    parameter int          SHEET_W      = 480,
    parameter int          FRAME_T      = 2,
    parameter int          BLINK_FRAMES = 16,
    parameter int          MEM_LAT      = 1,
    parameter logic [11:0] FRAME_COLOR  = DEF_FRAME_COLOR,
    parameter logic [11:0] BG_COLOR     = DEF_BG_COLOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              frame_tick,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_confirm,
    input  logic              btn_back,
    input  logic [11:0]       poke_mem_vga_data,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [11:0]       vga_data,
    output logic [7:0]        pokemon_id,
    output logic              locked,
    output logic              chosen
);

    localparam int TILE = IMG << SCALE_SH;
    localparam int CW   = idx_w(COLS);
    localparam int RW   = idx_w(ROWS);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          frame_visible;

    grid_cursor #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .BLINK_FRAMES (BLINK_FRAMES),
        .CW           (CW),
        .RW           (RW)
    ) u_cursor (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .btn_confirm     (btn_confirm),
        .btn_back        (btn_back),
        .col_o           (col),
        .row_o           (row),
        .locked_o        (locked),
        .chosen_o        (chosen),
        .frame_visible_o (frame_visible)
    );

    assign pokemon_id = 8'(32'(row) * COLS + 32'(col) + 1);

    logic [31:0] hx, vx;
    logic [31:0] tx, ty;
    logic [31:0] fx, fy;
    logic        tile_hit;
    logic        ring_box;
    logic        in_cur;
    pix_cls_e    cls0;

    assign hx = 32'(h_cnt);
    assign vx = 32'(v_cnt);

    // Tile hit search and sprite-sheet address.
    always_comb begin
        tile_hit   = 1'b0;
        pixel_addr = '0;
        tx         = '0;
        ty         = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                tx = 32'(H0 + c * H_PITCH);
                ty = 32'(V0 + r * V_PITCH);
                if (hx >= tx && hx < tx + TILE &&
                    vx >= ty && vx < ty + TILE) begin
                    tile_hit   = 1'b1;
                    pixel_addr = ADDR_W'(
                        ((vx - ty) >> SCALE_SH) * SHEET_W +
                        32'((r * COLS + c) * IMG) +
                        ((hx - tx) >> SCALE_SH));
                end
            end
        end
    end

    // Highlight ring around the cursor tile and class pick.
    always_comb begin
        fx = 32'(H0) + 32'(col) * H_PITCH;
        fy = 32'(V0) + 32'(row) * V_PITCH;
        ring_box = (hx + FRAME_T >= fx) &&
                   (hx < fx + TILE + FRAME_T) &&
                   (vx + FRAME_T >= fy) &&
                   (vx < fy + TILE + FRAME_T);
        in_cur = (hx >= fx) && (hx < fx + TILE) &&
                 (vx >= fy) && (vx < fy + TILE);
        if (frame_visible && ring_box && !in_cur)
            cls0 = CLS_FRAME;
        else if (tile_hit)
            cls0 = CLS_TILE;
        else
            cls0 = CLS_BG;
    end

    pix_cls_e    cls_q [MEM_LAT];
    pix_cls_e    cls_d [MEM_LAT];
    logic [11:0] vga_q, vga_d;

    // Class delay matching the BRAM latency, then colour mux.
    always_comb begin
        cls_d[0] = cls0;
        for (int i = 1; i < MEM_LAT; i++)
            cls_d[i] = cls_q[i-1];
        unique case (cls_q[MEM_LAT-1])
            CLS_FRAME: vga_d = FRAME_COLOR;
            CLS_TILE:  vga_d = poke_mem_vga_data;
            default:   vga_d = BG_COLOR;
        endcase
    end

    // Pixel pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_q <= '0;
            for (int i = 0; i < MEM_LAT; i++)
                cls_q[i] <= CLS_BG;
        end else begin
            vga_q <= vga_d;
            for (int i = 0; i < MEM_LAT; i++)
                cls_q[i] <= cls_d[i];
        end
    end

    assign vga_data = vga_q;

endmodule

// File: tb/tb_choose_grid_scene.sv
// Self-checking bench for choose_grid_scene: directed
// scenarios plus randomized run against a reference model.
module tb_choose_grid_scene;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int IMG = 60;
    localparam int SH = 1;
    localparam int TILE = IMG << SH;
    localparam int H0 = 20;
    localparam int V0 = 80;
    localparam int HP = 160;
    localparam int VP = 160;
    localparam int SW = 480;
    localparam int FT = 2;
    localparam int BF = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_confirm = 1'b0;
    logic        btn_back = 1'b0;
    logic [11:0] mem_q;
    logic [16:0] pixel_addr;
    logic [11:0] vga_data;
    logic [7:0]  pokemon_id;
    logic        locked;
    logic        chosen;

    int errs = 0;
    int checks = 0;

    choose_grid_scene dut (
        .clk               (clk),
        .rst               (rst),
        .h_cnt             (h_cnt),
        .v_cnt             (v_cnt),
        .frame_tick        (frame_tick),
        .btn_left          (btn_left),
        .btn_right         (btn_right),
        .btn_up            (btn_up),
        .btn_down          (btn_down),
        .btn_confirm       (btn_confirm),
        .btn_back          (btn_back),
        .poke_mem_vga_data (mem_q),
        .pixel_addr        (pixel_addr),
        .vga_data          (vga_data),
        .pokemon_id        (pokemon_id),
        .locked            (locked),
        .chosen            (chosen)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] memf(input logic [16:0] a);
        int t;
        t = int'(a) * 7 + 'h5a3;
        return t[11:0];
    endfunction

    // Sprite BRAM with one cycle of read latency.
    always @(posedge clk) mem_q <= memf(pixel_addr);

    // Reference: class 0=bg 1=tile 2=frame, plus sheet address.
    function automatic void mpix(input int h, input int v,
                                 input int mc, input int mr,
                                 input bit vis,
                                 output int cls, output int addr);
        int c, r, ox, oy, tx0, ty0;
        cls = 0;
        addr = 0;
        if (h >= H0 && v >= V0) begin
            c = (h - H0) / HP;
            ox = (h - H0) % HP;
            r = (v - V0) / VP;
            oy = (v - V0) % VP;
            if (c < COLS && r < ROWS && ox < TILE && oy < TILE) begin
                cls = 1;
                addr = ((oy >> SH) * SW + (r * COLS + c) * IMG
                        + (ox >> SH)) % (1 << 17);
            end
        end
        tx0 = H0 + mc * HP;
        ty0 = V0 + mr * VP;
        if (vis && h >= tx0 - FT && h < tx0 + TILE + FT &&
            v >= ty0 - FT && v < ty0 + TILE + FT &&
            !(h >= tx0 && h < tx0 + TILE &&
              v >= ty0 && v < ty0 + TILE))
            cls = 2;
    endfunction

    int          m_col, m_row, m_cnt, m_cls1, m_addr1;
    bit          m_lock, m_vis, m_chosen;
    logic [11:0] m_vga;

    // Behavioural model of cursor, blink and pixel stream.
    always @(posedge clk) begin : model
        int c0, a0, nc, nr, ncnt;
        bit nl, nv, mv;
        if (rst) begin
            m_col <= 0; m_row <= 0; m_cnt <= 0;
            m_lock <= 0; m_vis <= 1; m_chosen <= 0;
            m_vga <= 12'h000; m_cls1 <= 0; m_addr1 <= 0;
        end else begin
            m_vga <= (m_cls1 == 2) ? 12'h000 :
                     (m_cls1 == 1) ? memf(17'(m_addr1)) : 12'hfff;
            mpix(int'(h_cnt), int'(v_cnt), m_col, m_row, m_vis, c0, a0);
            m_cls1 <= c0;
            m_addr1 <= a0;
            nc = m_col; nr = m_row; nl = m_lock; mv = 0;
            m_chosen <= 0;
            if (!m_lock) begin
                if (btn_back) mv = 0;
                else if (btn_confirm) begin nl = 1; m_chosen <= 1; end
                else if (btn_left) begin nc = (m_col + COLS - 1) % COLS; mv = 1; end
                else if (btn_right) begin nc = (m_col + 1) % COLS; mv = 1; end
                else if (btn_up) begin nr = (m_row + ROWS - 1) % ROWS; mv = 1; end
                else if (btn_down) begin nr = (m_row + 1) % ROWS; mv = 1; end
            end else if (btn_back) nl = 0;
            ncnt = m_cnt; nv = m_vis;
            if (nl || mv) begin ncnt = 0; nv = 1; end
            else if (frame_tick) begin
                if (m_cnt == BF - 1) begin ncnt = 0; nv = !m_vis; end
                else ncnt = m_cnt + 1;
            end
            m_col <= nc; m_row <= nr; m_lock <= nl;
            m_cnt <= ncnt; m_vis <= nv;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input logic [5:0] b);
        {btn_back, btn_confirm, btn_left, btn_right, btn_up, btn_down} = b;
        step();
        {btn_back, btn_confirm, btn_left, btn_right, btn_up, btn_down} = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic set_px(input int h, input int v);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks += 4;
        if (pokemon_id !== 8'd1) begin errs++; $display("FAIL rst_id got %0d want 1", pokemon_id); end
        if (locked !== 1'b0) begin errs++; $display("FAIL rst_locked got %b want 0", locked); end
        if (chosen !== 1'b0) begin errs++; $display("FAIL rst_chosen got %b want 0", chosen); end
        if (vga_data !== 12'h000) begin errs++; $display("FAIL rst_vga got %h want 000", vga_data); end
        rst = 1'b0;
        set_px(20, 80);
        #1;
        checks++;
        if (pixel_addr !== 17'd0) begin errs++; $display("FAIL addr_20_80 got %0d want 0", pixel_addr); end
        step();
        step();
        checks++;
        if (vga_data !== memf(17'd0)) begin errs++; $display("FAIL vga_20_80 got %h want %h", vga_data, memf(17'd0)); end
        set_px(0, 0);
        step();
        step();
        checks++;
        if (vga_data !== 12'hfff) begin errs++; $display("FAIL vga_0_0 got %h want fff", vga_data); end
    endtask

    task automatic test_addr();
        set_px(181, 81);
        #1;
        checks++;
        if (pixel_addr !== 17'd60) begin errs++; $display("FAIL addr_181_81 got %0d want 60", pixel_addr); end
        step();
        step();
        checks++;
        if (vga_data !== memf(17'd60)) begin errs++; $display("FAIL vga_181_81 got %h want %h", vga_data, memf(17'd60)); end
        set_px(299, 199);
        #1;
        checks++;
        if (pixel_addr !== 17'd28439) begin errs++; $display("FAIL addr_299_199 got %0d want 28439", pixel_addr); end
        step();
        step();
        checks++;
        if (vga_data !== memf(17'd28439)) begin errs++; $display("FAIL vga_299_199 got %h want %h", vga_data, memf(17'd28439)); end
    endtask

    task automatic test_moves();
        int exp_r [4] = '{2, 3, 4, 1};
        for (int i = 0; i < 4; i++) begin
            pulse(6'b000100);
            checks++;
            if (pokemon_id !== 8'(exp_r[i])) begin errs++; $display("FAIL right_%0d got %0d want %0d", i, pokemon_id, exp_r[i]); end
        end
        pulse(6'b000010);
        checks++;
        if (pokemon_id !== 8'd5) begin errs++; $display("FAIL up_wrap got %0d want 5", pokemon_id); end
        pulse(6'b000001);
        checks++;
        if (pokemon_id !== 8'd1) begin errs++; $display("FAIL down_wrap got %0d want 1", pokemon_id); end
        pulse(6'b001001);
        checks++;
        if (pokemon_id !== 8'd4) begin errs++; $display("FAIL left_over_down got %0d want 4", pokemon_id); end
    endtask

    task automatic test_blink();
        pulse(6'b000100);
        pulse(6'b000001);
        pulse(6'b000100);
        checks++;
        if (pokemon_id !== 8'd6) begin errs++; $display("FAIL goto_6 got %0d want 6", pokemon_id); end
        set_px(178, 240);
        step();
        step();
        checks++;
        if (vga_data !== 12'h000) begin errs++; $display("FAIL blink_on0 got %h want 000", vga_data); end
        ticks(BF);
        step();
        step();
        checks++;
        if (vga_data !== 12'hfff) begin errs++; $display("FAIL blink_off got %h want fff", vga_data); end
        ticks(BF);
        step();
        step();
        checks++;
        if (vga_data !== 12'h000) begin errs++; $display("FAIL blink_on1 got %h want 000", vga_data); end
        ticks(BF);
        pulse(6'b001000);
        checks++;
        if (pokemon_id !== 8'd5) begin errs++; $display("FAIL blink_left got %0d want 5", pokemon_id); end
        set_px(18, 240);
        step();
        step();
        checks++;
        if (vga_data !== 12'h000) begin errs++; $display("FAIL move_visible got %h want 000", vga_data); end
    endtask

    task automatic test_lock();
        pulse(6'b000010);
        pulse(6'b000100);
        pulse(6'b000100);
        checks++;
        if (pokemon_id !== 8'd3) begin errs++; $display("FAIL goto_3 got %0d want 3", pokemon_id); end
        pulse(6'b010000);
        checks += 2;
        if (chosen !== 1'b1) begin errs++; $display("FAIL chosen_pulse got %b want 1", chosen); end
        if (locked !== 1'b1) begin errs++; $display("FAIL locked_set got %b want 1", locked); end
        step();
        checks++;
        if (chosen !== 1'b0) begin errs++; $display("FAIL chosen_one got %b want 0", chosen); end
        pulse(6'b000100);
        checks += 2;
        if (pokemon_id !== 8'd3) begin errs++; $display("FAIL lock_move got %0d want 3", pokemon_id); end
        if (chosen !== 1'b0) begin errs++; $display("FAIL lock_right_pulse got %b want 0", chosen); end
        pulse(6'b010000);
        checks += 2;
        if (chosen !== 1'b0) begin errs++; $display("FAIL lock_confirm got %b want 0", chosen); end
        if (locked !== 1'b1) begin errs++; $display("FAIL lock_hold got %b want 1", locked); end
        pulse(6'b100000);
        checks += 2;
        if (locked !== 1'b0) begin errs++; $display("FAIL back_unlock got %b want 0", locked); end
        if (pokemon_id !== 8'd3) begin errs++; $display("FAIL back_keep got %0d want 3", pokemon_id); end
    endtask

    task automatic test_rst_locked();
        pulse(6'b000001);
        pulse(6'b010000);
        checks += 2;
        if (pokemon_id !== 8'd7) begin errs++; $display("FAIL goto_7 got %0d want 7", pokemon_id); end
        if (locked !== 1'b1) begin errs++; $display("FAIL lock_7 got %b want 1", locked); end
        ticks(20);
        set_px(100, 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks += 3;
        if (pokemon_id !== 8'd1) begin errs++; $display("FAIL rst_lk_id got %0d want 1", pokemon_id); end
        if (locked !== 1'b0) begin errs++; $display("FAIL rst_lk_locked got %b want 0", locked); end
        if (vga_data !== 12'h000) begin errs++; $display("FAIL rst_lk_vga got %h want 000", vga_data); end
        set_px(18, 80);
        step();
        step();
        checks++;
        if (vga_data !== 12'h000) begin errs++; $display("FAIL rst_lk_frame got %h want 000", vga_data); end
    endtask

    task automatic test_random();
        int h, v, ec, ea;
        for (int i = 0; i < 1500; i++) begin
            btn_left = ($urandom % 24) == 0;
            btn_right = ($urandom % 24) == 0;
            btn_up = ($urandom % 24) == 0;
            btn_down = ($urandom % 24) == 0;
            btn_confirm = ($urandom % 40) == 0;
            btn_back = m_lock && (($urandom % 8) == 0);
            frame_tick = ($urandom % 3) == 0;
            if ($urandom % 2) begin
                h = H0 + m_col * HP - 4 + int'($urandom % (TILE + 8));
                v = V0 + m_row * VP - 4 + int'($urandom % (TILE + 8));
            end else begin
                h = int'($urandom % 800);
                v = int'($urandom % 525);
            end
            set_px(h, v);
            #1;
            mpix(h, v, m_col, m_row, m_vis, ec, ea);
            checks++;
            if (pixel_addr !== 17'(ea)) begin errs++; $display("FAIL rnd_addr i=%0d got %0d want %0d", i, pixel_addr, ea); end
            step();
            checks += 4;
            if (pokemon_id !== 8'(m_row * COLS + m_col + 1)) begin errs++; $display("FAIL rnd_id i=%0d got %0d want %0d", i, pokemon_id, m_row * COLS + m_col + 1); end
            if (locked !== m_lock) begin errs++; $display("FAIL rnd_locked i=%0d got %b want %b", i, locked, m_lock); end
            if (chosen !== m_chosen) begin errs++; $display("FAIL rnd_chosen i=%0d got %b want %b", i, chosen, m_chosen); end
            if (vga_data !== m_vga) begin errs++; $display("FAIL rnd_vga i=%0d got %h want %h", i, vga_data, m_vga); end
        end
        {btn_back, btn_confirm, btn_left, btn_right, btn_up, btn_down} = '0;
        frame_tick = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_addr();
        test_moves();
        test_blink();
        test_lock();
        test_rst_locked();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/choose_grid_scene.md
Name: choose_grid_scene

Overview:
- Parametrised selection-screen renderer: draws a ROWS x COLS grid of scaled sprite tiles from one sprite-sheet BRAM and frames the tile under a cursor.
- The cursor is moved and confirmed by button pulses.
- Owns the cursor state, blinking highlight, lock-on-confirm handshake and BRAM-latency alignment of the pixel stream.
- Sits between the VGA timing generator / sprite BRAM and the top-level scene mux.

Parameters:
COLS, 4, tiles per row
ROWS, 2, tile rows
IMG, 60, source sprite side in pixels (sheet holds tile k at x=k*IMG, y=0)
SCALE_SH, 1, log2 of upscale factor (tile side on screen TILE = IMG<<SCALE_SH)
H0, 20, screen x of tile (0,0) top-left
V0, 80, screen y of tile (0,0) top-left
H_PITCH, 160, horizontal tile pitch
V_PITCH, 160, vertical tile pitch
SHEET_W, 480, sprite-sheet row stride in pixels
FRAME_T, 2, highlight frame thickness; requires H0>=FRAME_T and V0>=FRAME_T
BLINK_FRAMES, 16, frame_tick count per blink half-period
MEM_LAT, 1, sprite BRAM read latency in cycles (>=1)
FRAME_COLOR, 12'h000, highlight colour
BG_COLOR, 12'hfff, background colour

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
h_cnt  in  10  current pixel x
v_cnt  in  10  current pixel y
frame_tick  in  1  one-cycle pulse per video frame
btn_left  in  1  one-cycle pulse: move cursor left
btn_right  in  1  one-cycle pulse: move cursor right
btn_up  in  1  one-cycle pulse: move cursor up
btn_down  in  1  one-cycle pulse: move cursor down
btn_confirm  in  1  one-cycle pulse: select current tile
btn_back  in  1  one-cycle pulse: release a selection
poke_mem_vga_data  in  12  BRAM read data, valid MEM_LAT cycles after its address
pixel_addr  out  17  BRAM read address (combinational from h_cnt/v_cnt)
vga_data  out  12  RGB444 pixel, registered
pokemon_id  out  8  1-based cursor index (row*COLS+col+1)
locked  out  1  selection held
chosen  out  1  one-cycle pulse when a selection is taken

Behaviour:
- Reset (synchronous, clk edge with rst=1): col=0, row=0 (pokemon_id=1), locked=0, chosen=0, vga_data=0, blink counter=0, blink phase=visible, every delay-pipe stage cleared to "background". rst mid-frame or mid-lock restores all of these on the next edge.
- Cursor FSM, states NAVIGATE / LOCKED:
  - At most one button acts per cycle. Priority: back > confirm > left > right > up > down.
  - NAVIGATE: left/right step col -1/+1, wrapping COLS-1<->0 within the row. up/down step row -1/+1, wrapping ROWS-1<->0. confirm -> LOCKED, chosen=1 for exactly that one cycle. back is ignored.
  - LOCKED: all moves and confirm are ignored; chosen stays 0. back -> NAVIGATE, and the cursor keeps its position.
  - locked=1 iff state is LOCKED.
- Blink:
  - Counter increments on frame_tick. Reaching BLINK_FRAMES-1 wraps it to 0 and toggles the phase.
  - Any applied cursor move resets the counter to 0 and the phase to visible.
  - In LOCKED the frame is always visible and the counter is held at 0.
- Pixel path, stage 0 (combinational):
  - Tile hit when h in [H0+c*H_PITCH, +TILE) and v in [V0+r*V_PITCH, +TILE) for some r<ROWS, c<COLS.
  - On a hit: dx=(h-tile_x)>>SCALE_SH, dy=(v-tile_y)>>SCALE_SH, pixel_addr = dy*SHEET_W + (r*COLS+c)*IMG + dx. Computed at 17 bits, truncated.
  - With no hit, pixel_addr=0.
  - Frame hit: pixel lies in the FRAME_T-wide ring around the cursor tile (outside the tile, inside tile+-FRAME_T) and the phase is visible.
  - Class = FRAME if frame hit, else TILE if tile hit, else BG. Frame has priority.
- Class is delayed MEM_LAT cycles in a shift register.
- On each edge vga_data <= FRAME_COLOR / poke_mem_vga_data / BG_COLOR according to the delayed class.
- Total latency from h_cnt/v_cnt to vga_data is MEM_LAT+1 cycles. The timing generator compensates.
- Cursor changes affect the frame class from the next cycle. Tearing mid-frame is accepted.

Decomposition:
- Package choose_scene_pkg: class encoding (BG=0, TILE=1, FRAME=2, 2 bits), default colours, ADDR_W=17.
- Sub-module grid_cursor: holds the NAVIGATE/LOCKED FSM, wrap logic, blink counter and chosen pulse. Outputs col, row, locked, chosen and frame_visible.
- The top level holds the hit/address datapath and the latency pipe.

Test Plan:
- Reset, then sample pixel (20,80) and (0,0) -> pokemon_id=1, locked=0. pixel_addr=0 at (20,80); after 2 cycles vga_data = mem data. (0,0) -> 12'hfff.
- Default params, pixel (181,81) -> tile 1, dx=0, dy=0, pixel_addr=60. Pixel (299,199) -> pixel_addr=59*480+60+59=28439.
- btn_right x4 from id 1 -> ids 2,3,4,1. btn_up from id 1 -> id 5. btn_left and btn_down asserted in the same cycle -> only left is applied (id wraps 1->4).
- Cursor at id 6: pixel (178,240) -> vga_data 12'h000 after 2 cycles. After 16 frame_ticks the same pixel gives 12'hfff; after 16 more it gives 12'h000 again. A btn_left in between restores visible immediately.
- btn_confirm at id 3 -> chosen high exactly 1 cycle, locked=1. Later btn_right and btn_confirm -> no change, no pulse. btn_back -> locked=0, id still 3.
- rst asserted while LOCKED at id 7 mid-frame -> next edge gives id 1, locked=0, vga_data 0, frame visible.
